// File: rtl/xnor_sched_pkg.sv
// +-----------------------------------------------------------------------+
// | xnor_sched_pkg: shared types and helpers for the XNOR-reduce scheduler |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package xnor_sched_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, REDUCE = 2'd1, DONE = 2'd2} sched_state_t;

   localparam int MAX_REQ   = 32;
   localparam int MAX_REQ_W = 5;

   function automatic int nchunk(input int data_width, input int chunk_width);
      return data_width / chunk_width;
   endfunction

   // Scan from last+num_req down to last+1 so the nearest index above last wins.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int last,
                                  input int num_req);
      int                   pick;
      logic [MAX_REQ_W-1:0] idx;
      pick = last;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= num_req) begin
            idx = MAX_REQ_W'((last + k) % num_req);
            if (valid[idx]) pick = int'(idx);
         end
      end
      return pick;
   endfunction

endpackage

`default_nettype wire

// File: rtl/xnor_B_to_A.sv
// +-----------------------------------------------------------------------+
// | xnor_B_to_A: single XNOR chain cell, folds input b into running a     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module xnor_B_to_A (
   input  logic       a,
   input  logic       b,
   input  logic [1:0] DigitSupply,
   output logic       y
);

   // Cell output collapses low unless the supply pair is at its nominal 2'b10.
   assign y = (DigitSupply == 2'b10) ? ~(a ^ b) : 1'b0;

endmodule

`default_nettype wire

// File: rtl/xnor_chunk.sv
// +-----------------------------------------------------------------------+
// | xnor_chunk: seeded XNOR chain over one chunk, ascending bit order     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module xnor_chunk #(
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                   seed,
   input  logic [1:0]             DigitSupply,
   input  logic [CHUNK_WIDTH-1:0] chunk,
   output logic                   result
);

   logic [CHUNK_WIDTH:0] w_t;

   assign w_t[0] = seed;

   generate
      for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_bit
         xnor_B_to_A u_cell (
            .a           (w_t[i]),
            .b           (chunk[i]),
            .DigitSupply (DigitSupply),
            .y           (w_t[i+1])
         );
      end
   endgenerate

   assign result = w_t[CHUNK_WIDTH];

endmodule

`default_nettype wire

// File: rtl/xnor_reduce_sched.sv
// +-----------------------------------------------------------------------+
// | xnor_reduce_sched: round-robin shared chunked XNOR-reduction engine   |
// | Option macro: XNOR_REDUCE_SCHED_FASTPATH_EN (grant straight from DONE)|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module xnor_reduce_sched
   import xnor_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8,
   parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
   input  logic                          Clock,
   input  logic                          nReset,
   input  logic [1:0]                    DigitSupply,
   input  logic [NUM_REQ-1:0]            reqValid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
   output logic [NUM_REQ-1:0]            reqReady,
   output logic                          resValid,
   input  logic                          resReady,
   output logic                          resData,
   output logic [ID_WIDTH-1:0]           resId,
   output logic                          busy
);

   localparam int NCHUNK = nchunk(DATA_WIDTH, CHUNK_WIDTH);
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_REDUCE = 2'(REDUCE);
   localparam logic [1:0] ST_DONE   = 2'(DONE);

   logic [1:0]            state_q, state_d;
   logic                  acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ID_WIDTH-1:0]   last_q, last_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;

   logic [DATA_WIDTH-1:0] w_words [NUM_REQ];
   logic [ID_WIDTH-1:0]   w_grant;
   logic                  w_accept_ok;
   logic                  w_accept;
   logic                  w_chain;

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
         assign w_words[i] = reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign w_grant = ID_WIDTH'(rr_pick(MAX_REQ'(reqValid), int'(last_q), NUM_REQ));

`ifdef XNOR_REDUCE_SCHED_FASTPATH_EN
   assign w_accept_ok = (state_q == ST_IDLE) || ((state_q == ST_DONE) && resReady);
`else
   assign w_accept_ok = (state_q == ST_IDLE);
`endif

   // Gated by nReset so no accept strobe is shown while reset is held.
   assign w_accept = w_accept_ok && (|reqValid) && nReset;
   assign reqReady = w_accept ? (NUM_REQ'(1) << w_grant) : '0;

   xnor_chunk #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_chunk (
      .seed        (acc_q),
      .DigitSupply (DigitSupply),
      .chunk       (sr_q[CHUNK_WIDTH-1:0]),
      .result      (w_chain)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      last_d  = last_q;
      sr_d    = sr_q;
      case (state_q)
         ST_REDUCE: begin
            acc_d = w_chain;
            sr_d  = sr_q >> CHUNK_WIDTH;
            if (cnt_q == CNT_W'(NCHUNK - 1)) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (resReady) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_accept) begin
         sr_d    = w_words[w_grant];
         acc_d   = 1'b1;
         cnt_d   = '0;
         id_d    = w_grant;
         last_d  = w_grant;
         state_d = ST_REDUCE;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         id_q    <= '0;
         last_q  <= ID_WIDTH'(NUM_REQ - 1);
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         last_q  <= last_d;
         sr_q    <= sr_d;
      end
   end

   assign resValid = (state_q == ST_DONE);
   assign resData  = acc_q;
   assign resId    = id_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_xnor_reduce_sched.sv
// +-----------------------------------------------------------------------+
// | tb_xnor_reduce_sched: directed self-checking bench for the scheduler  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_xnor_reduce_sched;

   logic         Clock       = 1'b0;
   logic         nReset      = 1'b0;
   logic [1:0]   DigitSupply = 2'b10;
   logic [3:0]   reqValid    = '0;
   logic [127:0] reqData     = '0;
   logic         resReady    = 1'b0;
   logic [3:0]   reqReady;
   logic         resValid;
   logic         resData;
   logic [1:0]   resId;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   xnor_reduce_sched #(
      .NUM_REQ     (4),
      .DATA_WIDTH  (32),
      .CHUNK_WIDTH (8)
   ) dut (
      .Clock       (Clock),
      .nReset      (nReset),
      .DigitSupply (DigitSupply),
      .reqValid    (reqValid),
      .reqData     (reqData),
      .reqReady    (reqReady),
      .resValid    (resValid),
      .resReady    (resReady),
      .resData     (resData),
      .resId       (resId),
      .busy        (busy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Seeded chain starting at 1, one XNOR per bit, ascending.
   function automatic logic ref_red(input logic [31:0] w);
      logic t;
      t = 1'b1;
      for (int i = 0; i < 32; i++) t = ~(t ^ w[i]);
      return t;
   endfunction

   // Called at a negedge with requests set; returns after the accept edge, at the next negedge.
   task automatic wait_grant(output logic [3:0] g);
      int n;
      n = 0;
      #1;
      while (reqReady == 4'b0 && n < 20) begin
         @(negedge Clock);
         #1;
         n++;
      end
      check("grant_seen", 32'(reqReady != 4'b0), 32'd1);
      g = reqReady;
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!resValid && lat < 30) begin
         @(negedge Clock);
         lat++;
      end
      check("result_seen", 32'(resValid), 32'd1);
   endtask

   task automatic one_req(input int r, input logic [31:0] w, input logic exp_d, input string tag);
      logic [3:0] g;
      int         lat;
      reqValid[r] = 1'b1;
      reqData[r*32 +: 32] = w;
      wait_grant(g);
      reqValid[r] = 1'b0;
      check({tag, "_grant"}, 32'(g), 32'(4'b0001 << r));
      wait_result(lat);
      check({tag, "_lat"}, 32'(lat), 32'd4);
      check({tag, "_data"}, 32'(resData), 32'(exp_d));
      check({tag, "_id"}, 32'(resId), 32'(r));
      @(negedge Clock);
   endtask

   initial begin
      logic [3:0]  g;
      int          lat;
      logic [31:0] words [4];
      logic        hold_d;
      logic [1:0]  hold_id;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         reqValid = 4'($urandom);
         reqData  = {$urandom, $urandom, $urandom, $urandom};
         resReady = 1'($urandom);
         #1;
         check("rst_reqReady", 32'(reqReady), 32'd0);
         check("rst_resValid", 32'(resValid), 32'd0);
         check("rst_resData", 32'(resData), 32'd0);
         check("rst_resId", 32'(resId), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      @(negedge Clock);
      reqValid = '0;
      reqData  = '0;
      resReady = 1'b1;
      nReset   = 1'b1;
      @(negedge Clock);
      check("idle_busy", 32'(busy), 32'd0);

      // Single request from requester 1
      reqValid = 4'b0010;
      reqData[32 +: 32] = 32'h0000_0001;
      #1;
      check("s2_ready", 32'(reqReady), 32'b0010);
      @(posedge Clock);
      @(negedge Clock);
      reqValid = '0;
      check("s2_ready_drop", 32'(reqReady), 32'd0);
      check("s2_busy", 32'(busy), 32'd1);
      check("s2_valid_early", 32'(resValid), 32'd0);
      wait_result(lat);
      check("s2_lat", 32'(lat), 32'd4);
      check("s2_data", 32'(resData), 32'd0);
      check("s2_id", 32'(resId), 32'd1);
      @(negedge Clock);
      check("s2_idle_busy", 32'(busy), 32'd0);
      check("s2_idle_valid", 32'(resValid), 32'd0);

      // Requester 2, three words
      one_req(2, 32'h0000_0000, 1'b1, "s3a");
      one_req(2, 32'hFFFF_FFFF, 1'b1, "s3b");
      one_req(2, 32'h8000_0003, 1'b0, "s3c");

      // Fresh round-robin state, then all four requesting continuously
      nReset = 1'b0;
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);
      words[0] = 32'h1234_5678;
      words[1] = 32'hDEAD_BEEF;
      words[2] = 32'h0000_00FF;
      words[3] = 32'h8000_0001;
      for (int i = 0; i < 4; i++) reqData[i*32 +: 32] = words[i];
      reqValid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(g);
         if (i == 4) reqValid = '0;
         check("s4_grant", 32'(g), 32'(4'b0001 << (i % 4)));
         wait_result(lat);
         check("s4_id", 32'(resId), 32'(i % 4));
         check("s4_data", 32'(resData), 32'(ref_red(words[i % 4])));
         @(negedge Clock);
      end

      // Backpressure in DONE while requester 0 waits
      resReady = 1'b0;
      reqValid = 4'b1000;
      reqData[96 +: 32] = 32'h0000_0003;
      wait_grant(g);
      check("s5_grant", 32'(g), 32'b1000);
      reqValid = 4'b0001;
      wait_result(lat);
      check("s5_lat", 32'(lat), 32'd4);
      hold_d  = 1'b1;
      hold_id = 2'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         check("s5_hold_valid", 32'(resValid), 32'd1);
         check("s5_hold_data", 32'(resData), 32'(hold_d));
         check("s5_hold_id", 32'(resId), 32'(hold_id));
         check("s5_hold_ready", 32'(reqReady), 32'd0);
      end
      resReady = 1'b1;
      @(negedge Clock);
      #1;
      check("s5_back_idle", 32'(busy), 32'd0);
      check("s5_idle_grant", 32'(reqReady), 32'b0001);
      reqValid = '0;
      @(negedge Clock);

      // Reset in REDUCE cycle 2
      reqValid = 4'b0100;
      reqData[64 +: 32] = 32'h0000_0005;
      wait_grant(g);
      reqValid = '0;
      @(negedge Clock);
      @(negedge Clock);
      check("s6_busy_pre", 32'(busy), 32'd1);
      nReset = 1'b0;
      #1;
      check("s6_rst_busy", 32'(busy), 32'd0);
      check("s6_rst_valid", 32'(resValid), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge Clock);
         check("s6_rst_hold_valid", 32'(resValid), 32'd0);
      end
      nReset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clock);
         check("s6_no_stale", 32'(resValid), 32'd0);
      end
      reqData[0 +: 32]  = 32'h0000_0007;
      reqData[96 +: 32] = 32'h0F0F_0F0E;
      reqValid = 4'b1001;
      wait_grant(g);
      check("s6_first_grant", 32'(g), 32'b0001);
      reqValid = 4'b1000;
      wait_result(lat);
      check("s6_id0", 32'(resId), 32'd0);
      check("s6_data0", 32'(resData), 32'd0);
      @(negedge Clock);
      wait_grant(g);
      reqValid = '0;
      check("s6_second_grant", 32'(g), 32'b1000);
      wait_result(lat);
      check("s6_id3", 32'(resId), 32'd3);
      check("s6_data3", 32'(resData), 32'd0);
      @(negedge Clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
